// File: rtl/board_pkg.sv
// Shared definitions for the board clear controller: board geometry,
// controller states, row slice positions and the row-collapse helper.
package board_pkg;

  localparam int NUM_ROWS = 3;
  localparam int ROW_W    = 4;
  localparam int BOARD_W  = 12;

  // Row slice LSB positions inside the 12-bit board word
  localparam int TOP_LSB = 2 * ROW_W;
  localparam int MID_LSB = 1 * ROW_W;
  localparam int BOT_LSB = 0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  // Remove the row selected by the one-hot code ([0] top, [1] middle,
  // [2] bottom) and drop every row above it down by one; top becomes empty.
  function automatic logic [BOARD_W-1:0] collapse_board(
    input logic [BOARD_W-1:0]  b,
    input logic [NUM_ROWS-1:0] onehot
  );
    logic [ROW_W-1:0] top_row;
    logic [ROW_W-1:0] mid_row;
    logic [ROW_W-1:0] bot_row;
    top_row = b[TOP_LSB +: ROW_W];
    mid_row = b[MID_LSB +: ROW_W];
    bot_row = b[BOT_LSB +: ROW_W];
    case (onehot)
      3'b001:  collapse_board = {{ROW_W{1'b0}}, mid_row, bot_row};
      3'b010:  collapse_board = {{ROW_W{1'b0}}, top_row, bot_row};
      3'b100:  collapse_board = {{ROW_W{1'b0}}, top_row, mid_row};
      default: collapse_board = b;
    endcase
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row priority detector. Output is one-hot with the
// top row winning: f[0] top, f[1] middle, f[2] bottom; zero if no row full.
module row_full_detect
  import board_pkg::*;
(
  input  logic [BOARD_W-1:0]  board,
  output logic [NUM_ROWS-1:0] f
);

  // row_full[0] is the bottom row, row_full[NUM_ROWS-1] the top row
  logic [NUM_ROWS-1:0] row_full;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign row_full[gi] = &board[gi*ROW_W +: ROW_W];
    end
  endgenerate

  // Priority encode top > middle > bottom into the output bit order
  always_comb begin
    f    = '0;
    f[0] = row_full[2];
    f[1] = row_full[1] & ~row_full[2];
    f[2] = row_full[0] & ~row_full[1] & ~row_full[2];
  end

endmodule

// File: rtl/board_clear_ctrl.sv
// Board clear sequencer: accepts drops in IDLE, then clears one full row
// per CHECK cycle (top first) with a saturating score, and pulses done
// when no full row remains.
// Optional feature macro: BOARD_CLEAR_COLLISION_EN rejects overlapping
// drops and pulses collision; when undefined overlaps are OR-merged.
module board_clear_ctrl
  import board_pkg::*;
#(
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               drop_valid,
  input  logic [11:0]        drop_cells,
  output logic               drop_ready,
  output logic [11:0]        board,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         clr_row,
  output logic               done,
  output logic               collision
);

  state_t               state_reg, state_next;
  logic [BOARD_W-1:0]   board_reg, board_next;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic [NUM_ROWS-1:0]  full_onehot;
  logic                 in_check;

  row_full_detect u_detect (
    .board (board_reg),
    .f     (full_onehot)
  );

  assign in_check   = (state_reg == CHECK);
  assign drop_ready = (state_reg == IDLE);
  assign board      = board_reg;
  assign score      = score_reg;

`ifdef BOARD_CLEAR_COLLISION_EN
  logic collision_reg, collision_next;
  assign collision = collision_reg;
`else
  assign collision = 1'b0;
`endif

  // Mealy outputs: detector result is only meaningful while checking
  always_comb begin
    clr_row = '0;
    done    = 1'b0;
    if (in_check) begin
      clr_row = full_onehot;
      done    = (full_onehot == '0);
    end
  end

  // Next-state, board merge/collapse and score update
  always_comb begin
    state_next = state_reg;
    board_next = board_reg;
    score_next = score_reg;
`ifdef BOARD_CLEAR_COLLISION_EN
    collision_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (drop_valid) begin
`ifdef BOARD_CLEAR_COLLISION_EN
          if ((board_reg & drop_cells) != '0) begin
            collision_next = 1'b1;
          end else begin
            board_next = board_reg | drop_cells;
            state_next = CHECK;
          end
`else
          board_next = board_reg | drop_cells;
          state_next = CHECK;
`endif
        end
      end
      CHECK: begin
        if (full_onehot == '0) begin
          state_next = IDLE;
        end else begin
          board_next = collapse_board(board_reg, full_onehot);
          if (score_reg != {SCORE_W{1'b1}}) begin
            score_next = score_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers; reset discards any partially collapsed board
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      board_reg <= '0;
      score_reg <= '0;
    end else begin
      state_reg <= state_next;
      board_reg <= board_next;
      score_reg <= score_next;
    end
  end

`ifdef BOARD_CLEAR_COLLISION_EN
  // Collision flag is registered so it pulses the cycle after the rejection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_reg <= 1'b0;
    end else begin
      collision_reg <= collision_next;
    end
  end
`endif

endmodule

// File: tb/tb_board_clear_ctrl.sv
// Testbench for board_clear_ctrl: table-driven drop vectors with a
// per-cycle expectation queue, plus hand sequences for collision and
// reset during CHECK. A second instance with SCORE_W=2 shares the inputs
// to exercise score saturation.
module tb_board_clear_ctrl;

  logic        clk;
  logic        rst_n;
  logic        drop_valid;
  logic [11:0] drop_cells;

  logic        drop_ready, drop_ready2;
  logic [11:0] board, board2;
  logic [7:0]  score;
  logic [1:0]  score2;
  logic [2:0]  clr_row, clr_row2;
  logic        done, done2;
  logic        collision, collision2;

  int errors = 0;
  int checks = 0;

  board_clear_ctrl #(.SCORE_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drop_valid (drop_valid),
    .drop_cells (drop_cells),
    .drop_ready (drop_ready),
    .board      (board),
    .score      (score),
    .clr_row    (clr_row),
    .done       (done),
    .collision  (collision)
  );

  board_clear_ctrl #(.SCORE_W(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .drop_valid (drop_valid),
    .drop_cells (drop_cells),
    .drop_ready (drop_ready2),
    .board      (board2),
    .score      (score2),
    .clr_row    (clr_row2),
    .done       (done2),
    .collision  (collision2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] cells;
    int          k;
    logic [2:0]  clr [3];
    logic [11:0] vis [4];
    logic [7:0]  sc;
    logic [1:0]  sc2;
  } vec_t;

  typedef struct {
    logic [2:0]  clr;
    logic        dn;
    logic [11:0] brd;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk_vec(
    input logic [11:0] cells, input int k,
    input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
    input logic [11:0] b0, input logic [11:0] b1, input logic [11:0] b2, input logic [11:0] b3,
    input logic [7:0] sc, input logic [1:0] sc2
  );
    vec_t v;
    v.cells  = cells;
    v.k      = k;
    v.clr[0] = c0; v.clr[1] = c1; v.clr[2] = c2;
    v.vis[0] = b0; v.vis[1] = b1; v.vis[2] = b2; v.vis[3] = b3;
    v.sc     = sc;
    v.sc2    = sc2;
    return v;
  endfunction

  // Wait (bounded) for ready, present one drop for one edge; returns at the
  // falling edge of the first cycle after acceptance.
  task automatic do_drop(input logic [11:0] cells);
    int guard;
    guard = 0;
    while (!drop_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!drop_ready) chk("ready_timeout", 32'(drop_ready), 32'd1);
    drop_valid = 1'b1;
    drop_cells = cells;
    @(negedge clk);
    drop_valid = 1'b0;
    drop_cells = 12'h000;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    for (int i = 0; i < v.k; i++) begin
      e.clr = v.clr[i];
      e.dn  = 1'b0;
      e.brd = v.vis[i];
      sb.push_back(e);
    end
    e.clr = 3'b000;
    e.dn  = 1'b1;
    e.brd = v.vis[v.k];
    sb.push_back(e);
    do_drop(v.cells);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_clr"},   32'(clr_row),    32'(e.clr));
      chk({tag, "_done"},  32'(done),       32'(e.dn));
      chk({tag, "_board"}, 32'(board),      32'(e.brd));
      chk({tag, "_busy"},  32'(drop_ready), 32'd0);
      chk({tag, "_clr2"},  32'(clr_row2),   32'(e.clr));
      chk({tag, "_done2"}, 32'(done2),      32'(e.dn));
      chk({tag, "_coll"},  32'(collision | collision2), 32'd0);
      @(negedge clk);
    end
    $display("drop %s cells=%03h board=%03h score=%0d score2=%0d", tag, v.cells, board, score, score2);
    chk({tag, "_ready"},  32'(drop_ready & drop_ready2), 32'd1);
    chk({tag, "_final"},  32'(board),  32'(v.vis[v.k]));
    chk({tag, "_final2"}, 32'(board2), 32'(v.vis[v.k]));
    chk({tag, "_score"},  32'(score),  32'(v.sc));
    chk({tag, "_score2"}, 32'(score2), 32'(v.sc2));
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_board"}, 32'(board),      32'h000);
    chk({tag, "_score"}, 32'(score),      32'd0);
    chk({tag, "_ready"}, 32'(drop_ready), 32'd1);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_clr"},   32'(clr_row),    32'd0);
    chk({tag, "_coll"},  32'(collision),  32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    drop_valid = 1'b0;
    drop_cells = 12'h000;

    //                cells   k  clr0    clr1    clr2    vis0    vis1    vis2    vis3    sc  sc2
    tbl[0] = mk_vec(12'h00F, 1, 3'b100, 3'b000, 3'b000, 12'h00F, 12'h000, 12'h000, 12'h000, 8'd1, 2'd1);
    tbl[1] = mk_vec(12'hFFF, 3, 3'b001, 3'b010, 3'b100, 12'hFFF, 12'h0FF, 12'h00F, 12'h000, 8'd4, 2'd3);
    tbl[2] = mk_vec(12'h10E, 0, 3'b000, 3'b000, 3'b000, 12'h10E, 12'h000, 12'h000, 12'h000, 8'd4, 2'd3);
    tbl[3] = mk_vec(12'h001, 1, 3'b100, 3'b000, 3'b000, 12'h10F, 12'h010, 12'h000, 12'h000, 8'd5, 2'd3);
    tbl[4] = mk_vec(12'h00F, 1, 3'b100, 3'b000, 3'b000, 12'h01F, 12'h001, 12'h000, 12'h000, 8'd6, 2'd3);
    tbl[5] = mk_vec(12'hF00, 1, 3'b001, 3'b000, 3'b000, 12'hF01, 12'h001, 12'h000, 12'h000, 8'd7, 2'd3);
    tbl[6] = mk_vec(12'h0F0, 1, 3'b010, 3'b000, 3'b000, 12'h0F1, 12'h001, 12'h000, 12'h000, 8'd8, 2'd3);

    // Reset held three cycles: outputs at reset values throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_vals($sformatf("reset%0d", i));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset");

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Overlapping drop onto board 00E
    pulse_reset();
    run_vec(mk_vec(12'h00E, 0, 3'b000, 3'b000, 3'b000, 12'h00E, 12'h000, 12'h000, 12'h000, 8'd0, 2'd0), "pre_overlap");
`ifdef BOARD_CLEAR_COLLISION_EN
    do_drop(12'h002);
    $display("collision drop cells=002 board=%03h collision=%0d", board, collision);
    chk("coll_pulse", 32'(collision),  32'd1);
    chk("coll_board", 32'(board),      32'h00E);
    chk("coll_ready", 32'(drop_ready), 32'd1);
    chk("coll_done",  32'(done),       32'd0);
    @(negedge clk);
    chk("coll_clear", 32'(collision),  32'd0);
    chk("coll_board2", 32'(board),     32'h00E);
    chk("coll_done2", 32'(done),       32'd0);
    chk("coll_score", 32'(score),      32'd0);
`else
    run_vec(mk_vec(12'h002, 0, 3'b000, 3'b000, 3'b000, 12'h00E, 12'h000, 12'h000, 12'h000, 8'd0, 2'd0), "overlap");
`endif

    // Reset asserted after the first clear of a full-board drop
    pulse_reset();
    do_drop(12'hFFF);
    chk("midrst_clr0", 32'(clr_row), 32'b001);
    @(negedge clk);
    chk("midrst_board1", 32'(board), 32'h0FF);
    rst_n = 1'b0;
    #1;
    $display("reset mid-check board=%03h score=%0d", board, score);
    chk_reset_vals("midrst_async");
    @(negedge clk);
    chk_reset_vals("midrst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_vals($sformatf("midrst_after%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
